seven_seg_scanner: RTL and testbench

- Parametrised, time-multiplexed driver for a common-anode multi-digit seven-segment display.
- Data path:
  - Captures a packed hex value, per-digit decimal points and an overflow flag on a load strobe.
  - Scans the digits at a programmable refresh rate and drives registered, active-low segment and anode lines.
- Sits between the datapath (counters, ALU results) and the board display pins.
- Display modes:
  - Leading-zero blanking.
  - All-dash overflow indication, encoded as the team's standard overflow pattern.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 21 ++
 rtl/seven_seg_scanner.sv | 129 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants shared by the scanner and its decoder.
// All patterns are {g,f,e,d,c,b,a}, active-low (common-anode display).
package seg7_pkg;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment decoder for the currently selected digit.
// Overflow dash takes priority over leading-zero blanking, which beats the hex glyph.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       overflow,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(nibble);
        if (overflow) begin
            seg = SEG_DASH;
        end else if (blank) begin
            seg = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with shadow registers,
// leading-zero blanking and overflow dashes; all pins are registered together.
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                overflow,
    input  logic                load,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [DIGITS-1:0]   an
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q, val_d;
    logic [DIGITS-1:0]   dps_q, dps_d;
    logic                ovf_q, ovf_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [DIGITS-1:0]   lz_mask;
    logic                upper_nz;
    logic [3:0]          sel_nib;
    logic                sel_dp;
    logic                sel_lz;
    logic                blank;
    logic [6:0]          dec_seg;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_comb begin
        val_d = val_q;
        dps_d = dps_q;
        ovf_d = ovf_q;
        if (load) begin
            val_d = value;
            dps_d = dp_in;
            ovf_d = overflow;
        end
    end

    // lz_mask[i] is set when digit i and every more-significant digit are zero
    always_comb begin
        upper_nz = 1'b0;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_nz   = upper_nz | (|val_q[4*i +: 4]);
            lz_mask[i] = ~upper_nz;
        end
    end

    always_comb begin
        sel_nib = val_q[3:0];
        sel_dp  = dps_q[0];
        sel_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib = val_q[4*i +: 4];
                sel_dp  = dps_q[i];
                sel_lz  = lz_mask[i];
            end
        end
        blank = (BLANK_LZ != 0) && (idx_q != '0) && sel_lz;
    end

    seg7_decode u_decode (
        .nibble   (sel_nib),
        .blank    (blank),
        .overflow (ovf_q),
        .seg      (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        dp_d  = ovf_q ? 1'b1 : ~sel_dp;
        an_d  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (idx_q != IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dps_q <= '0;
            ovf_q <= 1'b0;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            val_q <= val_d;
            dps_q <= dps_d;
            ovf_q <= ovf_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: four instances with different geometry
// share one stimulus stream and are compared against an arithmetic display model.
module tb_seven_seg_scanner;

    logic        clk;
    logic        reset;
    logic        load;
    logic        overflow;
    logic [31:0] stim_val;
    logic [7:0]  stim_dp;

    logic [6:0] seg_a, seg_b, seg_c, seg_d;
    logic       dp_a, dp_b, dp_c, dp_d;
    logic [3:0] an_a, an_b;
    logic [0:0] an_c;
    logic [7:0] an_d;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [15:0] e_c;
        logic [15:0] e_d;
    } exp_t;

    exp_t exp_q[$];

    int          n_edge;
    logic [31:0] sh_val;
    logic [7:0]  sh_dp;
    bit          sh_ovf;

    seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) dut_a (
        .clk(clk), .reset(reset), .value(stim_val[15:0]), .dp_in(stim_dp[3:0]),
        .overflow(overflow), .load(load), .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    seven_seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) dut_b (
        .clk(clk), .reset(reset), .value(stim_val[15:0]), .dp_in(stim_dp[3:0]),
        .overflow(overflow), .load(load), .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    seven_seg_scanner #(.DIGITS(1), .REFRESH_DIV(2), .BLANK_LZ(1)) dut_c (
        .clk(clk), .reset(reset), .value(stim_val[3:0]), .dp_in(stim_dp[0:0]),
        .overflow(overflow), .load(load), .seg(seg_c), .dp(dp_c), .an(an_c)
    );

    seven_seg_scanner #(.DIGITS(8), .REFRESH_DIV(3), .BLANK_LZ(1)) dut_d (
        .clk(clk), .reset(reset), .value(stim_val), .dp_in(stim_dp),
        .overflow(overflow), .load(load), .seg(seg_d), .dp(dp_d), .an(an_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pins after edge n show the digit lit during the n-th dwell slot of the frame
    function automatic logic [15:0] model(input int d, input int r, input bit blz, input int n,
                                          input logic [31:0] v, input logic [7:0] dpv, input bit ov);
        int         k;
        logic [3:0] nib;
        bit         upper_zero;
        logic [6:0] s;
        logic       dpo;
        logic [7:0] a;
        k = ((n - 1) / r) % d;
        nib = v[4*k +: 4];
        upper_zero = 1'b1;
        for (int j = k; j < d; j++) begin
            if (v[4*j +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (ov) s = 7'b0111111;
        else if (blz && k != 0 && upper_zero) s = 7'b1111111;
        else s = HEX_TBL[nib];
        dpo = ov ? 1'b1 : ~dpv[k];
        a = 8'hFF;
        a[k] = 1'b0;
        return {a, s, dpo};
    endfunction

    task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got {an,seg,dp}=%h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic check_dark(input string name);
        check_output({name, "_a"}, {4'hF, an_a, seg_a, dp_a}, 16'hFFFF);
        check_output({name, "_b"}, {4'hF, an_b, seg_b, dp_b}, 16'hFFFF);
        check_output({name, "_c"}, {7'h7F, an_c, seg_c, dp_c}, 16'hFFFF);
        check_output({name, "_d"}, {an_d, seg_d, dp_d}, 16'hFFFF);
    endtask

    // Drives one cycle of inputs and queues what the pins must show after the coming edge
    task automatic issue(input bit ld, input logic [31:0] v, input logic [7:0] dpv, input bit ov);
        exp_t e;
        load     = ld;
        stim_val = v;
        stim_dp  = dpv;
        overflow = ov;
        n_edge++;
        e.e_a = model(4, 4, 1'b1, n_edge, sh_val, sh_dp, sh_ovf);
        e.e_b = model(4, 4, 1'b0, n_edge, sh_val, sh_dp, sh_ovf);
        e.e_c = model(1, 2, 1'b1, n_edge, sh_val, sh_dp, sh_ovf);
        e.e_d = model(8, 3, 1'b1, n_edge, sh_val, sh_dp, sh_ovf);
        exp_q.push_back(e);
        if (ld) begin
            sh_val = v;
            sh_dp  = dpv;
            sh_ovf = ov;
        end
    endtask

    task automatic apply_stimulus(input bit ld, input logic [31:0] v, input logic [7:0] dpv, input bit ov);
        @(negedge clk);
        issue(ld, v, dpv, ov);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) apply_stimulus(1'b0, 32'h0, 8'h0, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b0;
        n_edge = 0;
        sh_val = '0;
        sh_dp  = '0;
        sh_ovf = 1'b0;
        issue(1'b0, 32'h0, 8'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("d4_blank", {4'hF, an_a, seg_a, dp_a}, e.e_a);
                check_output("d4_noblank", {4'hF, an_b, seg_b, dp_b}, e.e_b);
                check_output("d1_div2", {7'h7F, an_c, seg_c, dp_c}, e.e_c);
                check_output("d8_div3", {an_d, seg_d, dp_d}, e.e_d);
            end
        end
    end

    initial begin : driver
        bit          ld;
        bit          ov;
        logic [31:0] v;
        int          shift;
        reset    = 1'b1;
        load     = 1'b0;
        overflow = 1'b0;
        stim_val = '0;
        stim_dp  = '0;
        n_edge   = 0;
        sh_val   = '0;
        sh_dp    = '0;
        sh_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_dark("reset_hold");
        release_reset();
        idle(6);

        apply_stimulus(1'b1, 32'h0000_1234, 8'h00, 1'b0);
        idle(20);

        apply_stimulus(1'b1, 32'h0000_00A0, 8'h00, 1'b0);
        idle(20);

        apply_stimulus(1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b1);
        idle(30);
        apply_stimulus(1'b1, 32'hFFFF_FFFF, 8'h00, 1'b0);
        idle(10);

        while ((n_edge + 1) % 4 != 0) apply_stimulus(1'b0, 32'h0, 8'h0, 1'b0);
        apply_stimulus(1'b1, 32'h0000_5555, 8'b0000_0100, 1'b0);
        idle(20);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h0000_0700 + i, 8'h01, 1'b0);
        idle(12);

        // Mid-scan asynchronous reset, away from any clock edge
        @(negedge clk);
        load = 1'b0;
        #2 reset = 1'b1;
        #1 check_dark("reset_async");
        @(negedge clk);
        check_dark("reset_held");
        release_reset();
        idle(8);

        for (int i = 0; i < 450; i++) begin
            ld    = ($urandom_range(0, 3) == 0);
            ov    = ($urandom_range(0, 9) == 0);
            shift = $urandom_range(0, 8);
            v     = (shift == 8) ? 32'h0 : ($urandom >> (4 * shift));
            apply_stimulus(ld, v, 8'($urandom), ov);
        end
        idle(30);

        repeat (3) @(posedge clk);
        #2;
        check_output("queue_drain", 16'(exp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
